alu_cmd_queue: RTL and testbench

ALU_CMD_QUEUE -- requirements
Module: alu_cmd_queue

---
 rtl/alu_cmd_queue.sv | 84 ++++++++
 tb/tb_alu_cmd_queue.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_queue.sv
// Command FIFO sitting in front of a small ALU: buffers {op, a, b} entries
// and presents the head entry directly on the ALU operand/op wires.
module alu_cmd_queue #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [1:0]               in_op,
    input  logic [2:0]               in_a,
    input  logic [2:0]               in_b,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [1:0]               out_op,
    output logic [2:0]               out_a,
    output logic [2:0]               out_b,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   FULL     = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count_q;
    logic          run;
    logic          push;
    logic          pop;
    logic [7:0]    head;

    // in_ready stays low until the first clock edge after reset is released
    assign in_ready  = run && (count_q < FULL) && !flush;
    assign out_valid = (count_q != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready && !flush;
    assign head      = out_valid ? mem[rd_ptr] : 8'h00;
    assign {out_op, out_a, out_b} = head;
    assign count     = count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run <= 1'b0;
        end else begin
            run <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else if (flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (push && !pop) begin
                count_q <= count_q + CNT_ONE;
            end else if (pop && !push) begin
                count_q <= count_q - CNT_ONE;
            end
        end
    end

    // Storage is never cleared; stale contents are hidden by the output mask
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {in_op, in_a, in_b};
        end
    end

endmodule

// File: tb/tb_alu_cmd_queue.sv
// Randomised self-checking bench for alu_cmd_queue against a queue-based
// reference model of the FIFO behaviour.
module tb_alu_cmd_queue;

    localparam int DEPTH = 4;

    logic       clk;
    logic       rst_n;
    logic       flush;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] in_op;
    logic [2:0] in_a;
    logic [2:0] in_b;
    logic       out_valid;
    logic       out_ready;
    logic [1:0] out_op;
    logic [2:0] out_a;
    logic [2:0] out_b;
    logic [2:0] count;

    int total;
    int bad;

    logic [7:0] mq[$];
    bit         m_run;

    alu_cmd_queue #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_a(in_a), .in_b(in_b),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_op(out_op), .out_a(out_a), .out_b(out_b),
        .count(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [12:0] obs();
        return {in_ready, out_valid, count, out_op, out_a, out_b};
    endfunction

    function automatic logic [12:0] expv();
        logic rdy;
        logic [7:0] hd;
        rdy = m_run && (mq.size() < DEPTH) && !flush;
        hd  = (mq.size() != 0) ? mq[0] : 8'h00;
        return {rdy, mq.size() != 0, 3'(mq.size()), hd};
    endfunction

    // One clock: drive inputs, advance the model at the edge, land at edge+1
    task automatic tick(input logic v, input logic [7:0] cmd, input logic ordy, input logic fl);
        bit do_push;
        bit do_pop;
        in_valid  = v;
        {in_op, in_a, in_b} = cmd;
        out_ready = ordy;
        flush     = fl;
        #1;
        do_push = v && m_run && (mq.size() < DEPTH) && !fl;
        do_pop  = (mq.size() != 0) && ordy;
        @(posedge clk);
        if (rst_n) begin
            if (fl) begin
                mq.delete();
            end else begin
                if (do_pop) void'(mq.pop_front());
                if (do_push) mq.push_back(cmd);
            end
            m_run = 1'b1;
        end
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 3 * DEPTH && mq.size() != 0; i++) tick(1'b0, 8'h00, 1'b1, 1'b0);
        tick(1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        #3;
        total++;
        if (obs() !== 13'h0) begin
            bad++; $display("[TB] FAIL reset_async: got %h want %h", obs(), 13'h0);
        end
        @(posedge clk); #1;
        total++;
        if (obs() !== 13'h0) begin
            bad++; $display("[TB] FAIL reset_held: got %h want %h", obs(), 13'h0);
        end
        #2 rst_n = 1'b1;
        #1;
        total++;
        if (in_ready !== 1'b0) begin
            bad++; $display("[TB] FAIL ready_before_edge: got %b want 0", in_ready);
        end
        tick(1'b0, 8'h00, 1'b0, 1'b0);
        total++;
        if (in_ready !== 1'b1 || obs() !== expv()) begin
            bad++; $display("[TB] FAIL ready_after_edge: got %h want %h", obs(), expv());
        end
    endtask

    task automatic test_basic();
        logic [3:0] sum;
        tick(1'b1, {2'b00, 3'd3, 3'd2}, 1'b0, 1'b0);
        sum = {1'b0, out_a} + {1'b0, out_b};
        total++;
        if (out_valid !== 1'b1 || out_op !== 2'b00 || out_a !== 3'd3 || out_b !== 3'd2
            || count !== 3'd1 || sum !== 4'd5) begin
            bad++; $display("[TB] FAIL basic_push: got %h sum %0d want op0 a3 b2 cnt1 sum5", obs(), sum);
        end
        drain();
        total++;
        if (obs() !== expv() || out_valid !== 1'b0) begin
            bad++; $display("[TB] FAIL basic_drain: got %h want %h", obs(), expv());
        end
    endtask

    task automatic test_fill_full();
        logic [7:0] sent[5];
        for (int i = 0; i < 5; i++) begin
            sent[i] = 8'($urandom);
            tick(1'b1, sent[i], 1'b0, 1'b0);
            total++;
            if (obs() !== expv()) begin
                bad++; $display("[TB] FAIL fill_%0d: got %h want %h", i, obs(), expv());
            end
        end
        total++;
        if (count !== 3'd4 || in_ready !== 1'b0) begin
            bad++; $display("[TB] FAIL full_state: got cnt %0d rdy %b want cnt 4 rdy 0", count, in_ready);
        end
        for (int i = 0; i < 4; i++) begin
            total++;
            if ({out_op, out_a, out_b} !== sent[i] || out_valid !== 1'b1) begin
                bad++; $display("[TB] FAIL full_order_%0d: got %h want %h", i, {out_op, out_a, out_b}, sent[i]);
            end
            tick(1'b0, 8'h00, 1'b1, 1'b0);
        end
        total++;
        if (out_valid !== 1'b0 || count !== 3'd0 || {out_op, out_a, out_b} !== 8'h00) begin
            bad++; $display("[TB] FAIL full_empty: got %h want 0 entries", obs());
        end
    endtask

    task automatic test_stream();
        logic [7:0] order[$];
        logic [7:0] c;
        for (int i = 0; i < 2; i++) begin
            c = 8'($urandom);
            order.push_back(c);
            tick(1'b1, c, 1'b0, 1'b0);
        end
        for (int i = 0; i < 10; i++) begin
            c = 8'($urandom);
            total++;
            if ({out_op, out_a, out_b} !== order[0] || count !== 3'd2) begin
                bad++; $display("[TB] FAIL stream_%0d: got %h cnt %0d want %h cnt 2", i, {out_op, out_a, out_b}, count, order[0]);
            end
            void'(order.pop_front());
            order.push_back(c);
            tick(1'b1, c, 1'b1, 1'b0);
            total++;
            if (obs() !== expv()) begin
                bad++; $display("[TB] FAIL stream_model_%0d: got %h want %h", i, obs(), expv());
            end
        end
        drain();
    endtask

    task automatic test_full_pop_push();
        logic [7:0] c;
        for (int i = 0; i < 4; i++) tick(1'b1, 8'($urandom), 1'b0, 1'b0);
        c = 8'($urandom);
        tick(1'b1, c, 1'b1, 1'b0);
        total++;
        if (count !== 3'd3 || obs() !== expv()) begin
            bad++; $display("[TB] FAIL full_pop_only: got %h want %h", obs(), expv());
        end
        tick(1'b1, c, 1'b0, 1'b0);
        total++;
        if (count !== 3'd4 || obs() !== expv()) begin
            bad++; $display("[TB] FAIL full_push_next: got %h want %h", obs(), expv());
        end
        for (int i = 0; i < 4; i++) begin
            total++;
            if (obs() !== expv()) begin
                bad++; $display("[TB] FAIL full_drain_%0d: got %h want %h", i, obs(), expv());
            end
            tick(1'b0, 8'h00, 1'b1, 1'b0);
        end
    endtask

    task automatic test_flush();
        for (int i = 0; i < 3; i++) tick(1'b1, 8'($urandom), 1'b0, 1'b0);
        tick(1'b1, 8'hA5, 1'b1, 1'b1);
        flush = 1'b0;
        #1;
        total++;
        if (count !== 3'd0 || out_valid !== 1'b0 || {out_op, out_a, out_b} !== 8'h00 || obs() !== expv()) begin
            bad++; $display("[TB] FAIL flush: got %h want %h", obs(), expv());
        end
    endtask

    task automatic test_async_reset();
        tick(1'b1, 8'h1B, 1'b0, 1'b0);
        tick(1'b1, 8'h2C, 1'b0, 1'b0);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        mq.delete();
        m_run = 1'b0;
        #1;
        total++;
        if (out_valid !== 1'b0 || count !== 3'd0 || in_ready !== 1'b0 || obs() !== 13'h0) begin
            bad++; $display("[TB] FAIL async_reset: got %h want %h", obs(), 13'h0);
        end
        #3 rst_n = 1'b1;
        tick(1'b0, 8'h00, 1'b0, 1'b0);
        tick(1'b1, 8'hD2, 1'b0, 1'b0);
        total++;
        if ({out_op, out_a, out_b} !== 8'hD2 || count !== 3'd1 || obs() !== expv()) begin
            bad++; $display("[TB] FAIL post_reset_data: got %h want %h", obs(), expv());
        end
        drain();
    endtask

    task automatic test_random();
        int errs;
        errs = 0;
        for (int i = 0; i < 300; i++) begin
            tick(1'($urandom), 8'($urandom), 1'($urandom), ($urandom_range(0, 19) == 0));
            total++;
            if (obs() !== expv()) begin
                bad++; errs++;
                if (errs < 10) $display("[TB] FAIL random_%0d: got %h want %h", i, obs(), expv());
            end
        end
        drain();
    endtask

    initial begin
        total = 0; bad = 0; m_run = 1'b0;
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_op = 2'b00; in_a = 3'd0; in_b = 3'd0;
        test_reset();
        test_basic();
        test_fill_full();
        test_stream();
        test_full_pop_push();
        test_flush();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
